// File: rtl/memstream_sched_pkg.sv
// Shared types and helpers for the weight-memory read scheduler.
package memstream_sched_pkg;

  localparam int MAX_STREAMS = 6;
  localparam int STRM_ID_W   = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CFG   = 2'd2
  } sched_state_e;

  // Picks the per-stream value (offset or depth) for stream idx out of the flat parameter list.
  function automatic int strm_param(input int idx, input int p0, input int p1, input int p2,
                                    input int p3, input int p4, input int p5);
    case (idx)
      0:       return p0;
      1:       return p1;
      2:       return p2;
      3:       return p3;
      4:       return p4;
      default: return p5;
    endcase
  endfunction

endpackage

// File: rtl/memstream_rr_arbiter.sv
// Rotating-priority picker: the first requester at or after rr_ptr wins, wrapping modulo NSTREAMS.
module memstream_rr_arbiter
  import memstream_sched_pkg::*;
#(
  parameter int NSTREAMS = 4
) (
  input  logic [NSTREAMS-1:0]  req,
  input  logic [STRM_ID_W-1:0] rr_ptr,
  output logic [NSTREAMS-1:0]  gnt,
  output logic [STRM_ID_W-1:0] gnt_id,
  output logic                 any
);

  // First pass scans streams at/after rr_ptr, second pass wraps around to those before it.
  always_comb begin
    any    = 1'b0;
    gnt_id = '0;
    for (int j = 0; j < NSTREAMS; j++) begin
      if (!any && req[j] && (STRM_ID_W'(j) >= rr_ptr)) begin
        any    = 1'b1;
        gnt_id = STRM_ID_W'(j);
      end
    end
    for (int j = 0; j < NSTREAMS; j++) begin
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt_id = STRM_ID_W'(j);
      end
    end
  end

  // Expand the winning id into a one-hot grant vector.
  always_comb begin
    gnt = '0;
    for (int j = 0; j < NSTREAMS; j++) begin
      gnt[j] = any && (gnt_id == STRM_ID_W'(j));
    end
  end

endmodule

// File: rtl/memstream_read_scheduler.sv
// Shares the single memory read port among the output streams round-robin, tags returned
// data with its stream id after the fixed memory latency, and quiesces the port for config.
//
// Config handshake: cfg_req is a level request; cfg_gnt rises only once no read is left in
// flight and stays high until cfg_req drops. While cfg_gnt is high no read is issued. After
// cfg_req drops, cfg_gnt falls on the next cycle and reads resume the cycle after that.
module memstream_read_scheduler
  import memstream_sched_pkg::*;
#(
  parameter int NSTREAMS     = 4,
  parameter int ADDR_WIDTH   = 14,
  parameter int MEM_LATENCY  = 2,
  parameter int STRM0_OFFSET = 0,
  parameter int STRM1_OFFSET = 2304,
  parameter int STRM2_OFFSET = 4608,
  parameter int STRM3_OFFSET = 6912,
  parameter int STRM4_OFFSET = 9216,
  parameter int STRM5_OFFSET = 11520,
  parameter int STRM0_DEPTH  = 2304,
  parameter int STRM1_DEPTH  = 2304,
  parameter int STRM2_DEPTH  = 2304,
  parameter int STRM3_DEPTH  = 2304,
  parameter int STRM4_DEPTH  = 2304,
  parameter int STRM5_DEPTH  = 2304
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NSTREAMS-1:0]   strm_afull,
  input  logic                  restart,
  input  logic                  cfg_req,
  output logic                  cfg_gnt,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [NSTREAMS-1:0]   rdata_vld,
  output logic [NSTREAMS-1:0]   strm_wrap,
  output sched_state_e          dbg_state
);

  if (NSTREAMS < 1 || NSTREAMS > MAX_STREAMS) begin : g_bad_nstreams
    $error("memstream_read_scheduler: NSTREAMS must be 1..6");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("memstream_read_scheduler: MEM_LATENCY must be 1..4");
  end

  sched_state_e                             state_q;
  logic                                     cfg_gnt_q;
  logic                                     hold_q;     // blocks grants for one cycle after reset or CFG exit
  logic [STRM_ID_W-1:0]                     rr_q;
  logic [NSTREAMS-1:0]                      arb_gnt;
  logic [NSTREAMS-1:0]                      gnt;
  logic [STRM_ID_W-1:0]                     arb_id;
  logic                                     arb_any;
  logic                                     grant_en;
  logic [NSTREAMS-1:0][ADDR_WIDTH-1:0]      addr_sel;
  logic [MEM_LATENCY-1:0]                   vld_q;
  logic [MEM_LATENCY-1:0][STRM_ID_W-1:0]    id_q;
  logic                                     pipe_busy;

  memstream_rr_arbiter #(.NSTREAMS(NSTREAMS)) u_arb (
    .req    (~strm_afull),
    .rr_ptr (rr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign grant_en  = (state_q == RUN) && !hold_q && !restart;
  assign mem_rd_en = grant_en && arb_any;
  assign gnt       = arb_gnt & {NSTREAMS{grant_en}};
  assign cfg_gnt   = cfg_gnt_q;
  assign dbg_state = state_q;

  for (genvar i = 0; i < NSTREAMS; i++) begin : g_strm
    localparam int OFF = strm_param(i, STRM0_OFFSET, STRM1_OFFSET, STRM2_OFFSET,
                                    STRM3_OFFSET, STRM4_OFFSET, STRM5_OFFSET);
    localparam int DEP = strm_param(i, STRM0_DEPTH, STRM1_DEPTH, STRM2_DEPTH,
                                    STRM3_DEPTH, STRM4_DEPTH, STRM5_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_A  = ADDR_WIDTH'(OFF);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(OFF + DEP - 1);

    if (DEP < 1 || (longint'(OFF) + longint'(DEP)) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_range
      $error("memstream_read_scheduler: stream range must have depth >= 1 and fit in ADDR_WIDTH");
    end

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic                  at_last;

    assign at_last      = (ptr_q == LAST_A);
    assign addr_sel[i]  = gnt[i] ? ptr_q : '0;
    assign strm_wrap[i] = gnt[i] && at_last;

    // Rewind on restart; advance on grant, returning to the base after the last word.
    always_comb begin
      ptr_d = ptr_q;
      if (restart) begin
        ptr_d = OFF_A;
      end else if (gnt[i]) begin
        ptr_d = at_last ? OFF_A : ptr_q + ADDR_WIDTH'(1);
      end
    end

    // Per-stream read pointer register.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) ptr_q <= OFF_A;
      else          ptr_q <= ptr_d;
    end
  end

  // Only the granted stream contributes a non-zero address, so an OR merge acts as the mux.
  always_comb begin
    mem_rd_addr = '0;
    for (int j = 0; j < NSTREAMS; j++) begin
      mem_rd_addr = mem_rd_addr | addr_sel[j];
    end
  end

  // Round-robin pointer moves just past the stream that was granted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_q <= '0;
    end else if (restart) begin
      rr_q <= '0;
    end else if (mem_rd_en) begin
      rr_q <= (arb_id == STRM_ID_W'(NSTREAMS - 1)) ? '0 : arb_id + STRM_ID_W'(1);
    end
  end

  // Return-path shift register of {valid, id}; reads in flight are never cancelled except by reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= mem_rd_en;
      id_q[0]  <= arb_id;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
    end
  end

  // The last stage delivers this cycle, so only earlier stages keep the port busy.
  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < MEM_LATENCY - 1; k++) begin
      pipe_busy = pipe_busy | vld_q[k];
    end
  end

  // Decode the last stage into a one-hot data-valid tag.
  always_comb begin
    rdata_vld = '0;
    for (int j = 0; j < NSTREAMS; j++) begin
      rdata_vld[j] = vld_q[MEM_LATENCY-1] && (id_q[MEM_LATENCY-1] == STRM_ID_W'(j));
    end
  end

  // Port-ownership FSM with registered cfg_gnt.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= RUN;
      cfg_gnt_q <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      hold_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (cfg_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!pipe_busy) begin
            if (cfg_req) begin
              state_q   <= CFG;
              cfg_gnt_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        CFG: begin
          if (!cfg_req) begin
            state_q   <= RUN;
            cfg_gnt_q <= 1'b0;
            hold_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= RUN;
          cfg_gnt_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memstream_read_scheduler.sv
// Bench for memstream_read_scheduler: a 4-stream instance (depth 3 each) driven through
// round-robin, back-pressure, config quiesce, restart and mid-run reset, plus a 1-stream,
// depth-1 instance with toggling almost-full.
module tb_memstream_read_scheduler;
  import memstream_sched_pkg::*;

  localparam int AW  = 14;
  localparam int LAT = 2;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [3:0]       strm_afull = 4'hF;
  logic             restart = 1'b0;
  logic             cfg_req = 1'b0;
  logic             cfg_gnt;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_rd_addr;
  logic [3:0]       rdata_vld;
  logic [3:0]       strm_wrap;
  sched_state_e     dbg_state;

  logic [0:0]       afull_b = 1'b1;
  logic             restart_b = 1'b0;
  logic             cfg_req_b = 1'b0;
  logic             cfg_gnt_b;
  logic             mem_rd_en_b;
  logic [AW-1:0]    addr_b;
  logic [0:0]       rvld_b;
  logic [0:0]       wrap_b;
  sched_state_e     dbg_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [17:0] exp_q[$];  // expected grants: {id[2:0], wrap, addr[13:0]}
  logic [18:0] rv_q[$];   // expected data returns: {due_cycle[15:0], id[2:0]}

  memstream_read_scheduler #(
    .NSTREAMS(4), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT),
    .STRM0_DEPTH(3), .STRM1_DEPTH(3), .STRM2_DEPTH(3),
    .STRM3_DEPTH(3), .STRM4_DEPTH(3), .STRM5_DEPTH(3)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .strm_afull(strm_afull), .restart(restart),
    .cfg_req(cfg_req), .cfg_gnt(cfg_gnt), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .rdata_vld(rdata_vld), .strm_wrap(strm_wrap), .dbg_state(dbg_state)
  );

  memstream_read_scheduler #(
    .NSTREAMS(1), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT),
    .STRM0_OFFSET(100), .STRM0_DEPTH(1)
  ) dut_b (
    .aclk(aclk), .aresetn(aresetn), .strm_afull(afull_b), .restart(restart_b),
    .cfg_req(cfg_req_b), .cfg_gnt(cfg_gnt_b), .mem_rd_en(mem_rd_en_b), .mem_rd_addr(addr_b),
    .rdata_vld(rvld_b), .strm_wrap(wrap_b), .dbg_state(dbg_b)
  );

  // Clock and cycle counter
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge aclk);
  endtask

  task automatic push_grant(input int id, input int addr, input bit wrap);
    exp_q.push_back({3'(id), wrap, 14'(addr)});
  endtask

  task automatic run(input logic [3:0] af, input int n);
    step();
    strm_afull = af;
    repeat (n - 1) step();
  endtask

  // Scoreboard monitor for the 4-stream instance
  always @(negedge aclk) begin
    logic [17:0] e;
    logic [18:0] r;
    logic [3:0]  ev;
    if (aresetn) begin
      if (mem_rd_en) begin
        if (exp_q.size() == 0) begin
          check("grant_unexpected", {18'd0, mem_rd_addr}, 32'hFFFF_FFFF);
        end else begin
          e  = exp_q.pop_front();
          check("rd_addr", {18'd0, mem_rd_addr}, {18'd0, e[13:0]});
          ev = e[14] ? (4'b0001 << e[17:15]) : 4'b0000;
          check("strm_wrap", {28'd0, strm_wrap}, {28'd0, ev});
          rv_q.push_back({16'(cyc + LAT), e[17:15]});
        end
      end else begin
        check("wrap_idle", {28'd0, strm_wrap}, 32'd0);
      end
      if (rdata_vld != 4'd0) begin
        if (rv_q.size() == 0) begin
          check("rdata_unexpected", {28'd0, rdata_vld}, 32'd0);
        end else begin
          r = rv_q.pop_front();
          check("rdata_id", {28'd0, rdata_vld}, {28'd0, 4'b0001 << r[2:0]});
          check("rdata_lat", cyc, {16'd0, r[18:3]});
        end
      end
    end
  end

  initial begin
    bit pat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_rv;

    // Reset state
    repeat (3) @(posedge aclk);
    at_neg();
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_cfg_gnt", {31'd0, cfg_gnt}, 32'd0);
    check("rst_rdata_vld", {28'd0, rdata_vld}, 32'd0);
    check("rst_wrap", {28'd0, strm_wrap}, 32'd0);
    check("rst_addr", {18'd0, mem_rd_addr}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, RUN});
    step();
    aresetn = 1'b1;
    step();

    // All streams eligible: 0,1,2,3 rotation, depth 3 per stream, then 5 more grants
    for (int g = 0; g < 12; g++) push_grant(g % 4, (g % 4) * 2304 + (g / 4), (g / 4) == 2);
    push_grant(0, 0, 0); push_grant(1, 2304, 0); push_grant(2, 4608, 0);
    push_grant(3, 6912, 0); push_grant(0, 1, 0);
    run(4'b0000, 17);

    // Streams 0 and 2 almost-full: 1 and 3 alternate
    push_grant(1, 2305, 0); push_grant(3, 6913, 0); push_grant(1, 2306, 1);
    push_grant(3, 6914, 1); push_grant(1, 2304, 0); push_grant(3, 6912, 0);
    run(4'b0101, 6);
    // Release: 0 and 2 resume at frozen addresses
    push_grant(0, 2, 1); push_grant(1, 2305, 0); push_grant(2, 4609, 0); push_grant(3, 6913, 0);
    run(4'b0000, 4);

    // Config quiesce mid-stream
    push_grant(0, 0, 0); push_grant(1, 2306, 1); push_grant(2, 4610, 1); push_grant(3, 6914, 1);
    push_grant(0, 1, 0); push_grant(1, 2304, 0); push_grant(2, 4608, 0); push_grant(3, 6912, 0);
    run(4'b0000, 2);
    step(); cfg_req = 1'b1;                 // last grant cycle L
    step(); at_neg();                       // L+1
    check("cfg_rd_en_drop", {31'd0, mem_rd_en}, 32'd0);
    check("cfg_state_drain", {30'd0, dbg_state}, {30'd0, DRAIN});
    step(); at_neg();                       // L+2
    check("cfg_gnt_early", {31'd0, cfg_gnt}, 32'd0);
    step(); at_neg();                       // L+3
    check("cfg_gnt_rise", {31'd0, cfg_gnt}, 32'd1);
    check("cfg_rd_en_quiet", {31'd0, mem_rd_en}, 32'd0);
    step(); step();
    step(); cfg_req = 1'b0; at_neg();       // D
    check("cfg_gnt_hold", {31'd0, cfg_gnt}, 32'd1);
    step(); at_neg();                       // D+1
    check("cfg_gnt_fall", {31'd0, cfg_gnt}, 32'd0);
    check("cfg_resume_wait", {31'd0, mem_rd_en}, 32'd0);
    step(); at_neg();                       // D+2
    check("cfg_resume", {31'd0, mem_rd_en}, 32'd1);
    repeat (4) step();

    // Restart with two reads in flight
    step(); restart = 1'b1; at_neg();
    check("restart_no_grant", {31'd0, mem_rd_en}, 32'd0);
    push_grant(0, 0, 0); push_grant(1, 2304, 0); push_grant(2, 4608, 0); push_grant(3, 6912, 0);
    step(); restart = 1'b0;
    repeat (3) step();

    // Reset asserted with two reads in flight
    push_grant(0, 1, 0); push_grant(1, 2305, 0);
    step(); step();
    step(); aresetn = 1'b0; strm_afull = 4'hF; rv_q.delete(); at_neg();
    check("mid_rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("mid_rst_rdata", {28'd0, rdata_vld}, 32'd0);
    check("mid_rst_cfg_gnt", {31'd0, cfg_gnt}, 32'd0);
    step(); aresetn = 1'b1;
    push_grant(0, 0, 0); push_grant(1, 2304, 0);
    step(); strm_afull = 4'h0;
    step();
    step(); strm_afull = 4'hF;
    repeat (4) step();

    // Single stream, depth 1, almost-full toggling
    for (int k = 0; k < 10; k++) begin
      step(); afull_b = pat[k];
      at_neg();
      exp_rv = 1'b0;
      if (k >= 2) exp_rv = !pat[k-2];
      check("b_rd_en", {31'd0, mem_rd_en_b}, {31'd0, !pat[k]});
      if (!pat[k]) check("b_addr", {18'd0, addr_b}, 32'd100);
      check("b_wrap", {31'd0, wrap_b}, {31'd0, !pat[k]});
      check("b_rdata", {31'd0, rvld_b}, {31'd0, exp_rv});
    end

    // Everything expected must have been consumed
    repeat (4) step();
    check("grants_left", exp_q.size(), 32'd0);
    check("rdata_left", rv_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
